shift_ena_gen: RTL
==================

// Module: shift_ena_gen
// PURPOSE
//   Parametrised successor to the fixed 4-cycle post-reset shift-enable FSM.
//   Asserts shift_ena for RESET_LEN cycles after reset, then re-arms on demand: each accepted
//   start runs an optional PRE_DLY wait, then a shift window of run-time length len.
//   Sits in the control path ahead of a serial shift register / pattern loader.
// PARAMETERS
//   RESET_LEN  4   shift_ena cycles after reset deasserts; 0 = come out of reset idle
//   MAX_LEN    16  largest run-time window; len==0 means MAX_LEN
//   PRE_DLY    0   idle-low cycles between an accepted start and the window; 0 = none
//   LEN_W      $clog2(MAX_LEN+1)  width of len / remaining (derived, do not override)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      request a new window; sampled every cycle
//   len        in   LEN_W  window length, latched on accepted start; 0 or >MAX_LEN -> MAX_LEN
//   shift_ena  out  1      shift enable (Moore, decoded from state)
//   busy       out  1      1 in DELAY or SHIFT
//   done       out  1      one-cycle pulse in the first cycle after a window ends
//   start_drop out  1      one-cycle pulse: start seen while busy (ignored)
//   remaining  out  LEN_W  shift cycles still to go incl. current; 0 when not shifting
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. All state registered on clk.
//   - States: IDLE, DELAY, SHIFT. shift_ena=(state==SHIFT); busy=(state!=IDLE).
//   - Reset (RESET_LEN>0): state<=SHIFT, cnt<=RESET_LEN; shift_ena=1 while reset held and for
//     exactly RESET_LEN cycles after the last edge reset is sampled high. RESET_LEN=0: IDLE.
//   - Reset values: done=0, start_drop=0, busy=(RESET_LEN>0), remaining=RESET_LEN.
//   - Reset overrides everything, incl. mid-window and same-cycle start.
//   - IDLE & start: latch L=len (clamped); PRE_DLY>0 -> DELAY, dcnt=PRE_DLY; else SHIFT, cnt=L.
//     Start sampled in cycle t -> shift_ena high cycles t+1+PRE_DLY .. t+PRE_DLY+L.
//   - DELAY: dcnt decrements; at dcnt==1 -> SHIFT, cnt=L.
//   - SHIFT: cnt decrements; at cnt==1 -> IDLE, done=1 next cycle.
//   - Back-to-back: start sampled in the done cycle is accepted (state already IDLE);
//     zero-gap windows are impossible, minimum gap 1 cycle low.
//   - start while busy: ignored, start_drop=1 next cycle; never extends/restarts a window.
//   - Post-reset window end also pulses done.
//   - remaining = cnt in SHIFT, else 0. Counters never wrap: decrement only when >=1.
// CONFIGURATION
//   SHIFT_ENA_PAUSE_EN defined: extra input `pause` (1 bit, after start). While pause=1 in
//     DELAY/SHIFT: counters hold, shift_ena forced 0, busy stays 1; resumes next cycle after
//     pause drops; start during pause -> start_drop. Pause in IDLE has no effect.
//   Not defined: no pause port; windows always run uninterrupted.
// STRUCTURE
//   shift_ena_pkg: state enum (IDLE/DELAY/SHIFT), clamp_len() function, LEN_W helper.
//   Sub-module shift_win_cnt: loadable saturating down-counter (load, val, dec, zero/one flags),
//   instantiated twice (delay and window counters). Top holds FSM and output decode.
// TESTING
//   1 Defaults, reset 2 cycles then low -> shift_ena=1 during reset + 4 cycles, then 0; done
//     pulses once; repeat reset mid-window -> window restarts at 4.
//   2 start with len=3 in IDLE at cycle t -> shift_ena t+1..t+3, remaining 3,2,1, done at t+4.
//   3 len=0 and len=20 (MAX_LEN=16) -> both give 16-cycle windows.
//   4 start held high continuously -> windows of L separated by exactly 1 low cycle;
//     start_drop pulses every busy cycle.
//   5 PRE_DLY=2, len=2 start at t -> busy t+1..t+4, shift_ena t+3..t+4, done t+5.
//   6 SHIFT_ENA_PAUSE_EN, len=4, pause 3 cycles after 2nd shift cycle -> 4 total high cycles
//     with 3-cycle hole; random reset/start/pause vs. behavioural model: zero mismatches.

Source files
------------

// File: rtl/shift_ena_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_ena_pkg
// Purpose : Shared state encoding and length helpers for shift_ena_gen.
// Rev     : 1.0  initial release
// ============================================================================
package shift_ena_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int unsigned len_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   // A zero or oversized request selects the longest window.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      if (len == 0 || len > max_len) begin
         return max_len;
      end
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_win_cnt.sv
`default_nettype none
// ============================================================================
// Module  : shift_win_cnt
// Purpose : Loadable down-counter that saturates at zero, with zero/one flags.
// Rev     : 1.0  initial release
// ============================================================================
module shift_win_cnt #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o,
   output logic         one_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // No reset port: the owner drives load_i during its synchronous reset.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/shift_ena_gen.sv
`default_nettype none
// ============================================================================
// Module  : shift_ena_gen
// Purpose : Post-reset and on-demand shift-enable window generator with an
//           optional pre-window delay. Define SHIFT_ENA_PAUSE_EN to add the
//           pause input that freezes a running delay/window.
// Rev     : 1.0  initial release
// ============================================================================
module shift_ena_gen
   import shift_ena_pkg::*;
#(
   parameter int unsigned RESET_LEN = 4,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned PRE_DLY   = 0,
   parameter int unsigned LEN_W     = len_width(MAX_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SHIFT_ENA_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [LEN_W-1:0] len,
   output logic             shift_ena,
   output logic             busy,
   output logic             done,
   output logic             start_drop,
   output logic [LEN_W-1:0] remaining
);

   localparam int unsigned DLY_W       = (PRE_DLY > 0) ? len_width(PRE_DLY) : 1;
   localparam state_e      RESET_STATE = (RESET_LEN > 0) ? ST_SHIFT : ST_IDLE;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;

   logic               w_pause;
   logic               w_accept;
   logic [LEN_W-1:0]   w_len_clamped;
   logic               w_win_load, w_win_dec, w_win_zero, w_win_one;
   logic [LEN_W-1:0]   w_win_val, w_win_cnt;
   logic               w_dly_load, w_dly_dec, w_dly_zero, w_dly_one;
   logic [DLY_W-1:0]   w_dly_val, w_dly_cnt;
   logic               w_dly_unused;

`ifdef SHIFT_ENA_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   assign w_accept      = (state_q == ST_IDLE) && start;
   assign w_len_clamped = LEN_W'(clamp_len(32'(len), MAX_LEN));

   // Window counter loads on reset, on a direct start, or when the delay expires.
   assign w_win_load = reset
                     || (w_accept && (PRE_DLY == 0))
                     || ((state_q == ST_DELAY) && !w_pause && (w_dly_one || w_dly_zero));
   assign w_win_val  = reset ? LEN_W'(RESET_LEN)
                     : ((state_q == ST_IDLE) ? w_len_clamped : len_q);
   assign w_win_dec  = (state_q == ST_SHIFT) && !w_pause;

   assign w_dly_load = reset || w_accept;
   assign w_dly_val  = reset ? '0 : DLY_W'(PRE_DLY);
   assign w_dly_dec  = (state_q == ST_DELAY) && !w_pause;

   shift_win_cnt #(.W(LEN_W)) u_win_cnt (
      .clk    (clk),
      .load_i (w_win_load),
      .val_i  (w_win_val),
      .dec_i  (w_win_dec),
      .cnt_o  (w_win_cnt),
      .zero_o (w_win_zero),
      .one_o  (w_win_one)
   );

   shift_win_cnt #(.W(DLY_W)) u_dly_cnt (
      .clk    (clk),
      .load_i (w_dly_load),
      .val_i  (w_dly_val),
      .dec_i  (w_dly_dec),
      .cnt_o  (w_dly_cnt),
      .zero_o (w_dly_zero),
      .one_o  (w_dly_one)
   );

   assign w_dly_unused = ^w_dly_cnt;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      done_d  = 1'b0;
      drop_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d   = w_len_clamped;
               state_d = (PRE_DLY > 0) ? ST_DELAY : ST_SHIFT;
            end
         end
         ST_DELAY: begin
            drop_d = start;
            if (!w_pause && (w_dly_one || w_dly_zero)) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            drop_d = start;
            if (!w_pause && (w_win_one || w_win_zero)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET_STATE;
         len_q   <= LEN_W'(MAX_LEN);
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   assign shift_ena  = (state_q == ST_SHIFT) && !w_pause;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign start_drop = drop_q;
   assign remaining  = (state_q == ST_SHIFT) ? w_win_cnt : '0;

endmodule
`default_nettype wire
